// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl
//   On each rising edge of compute_done, reads one output row (X_dim psums) from the
//   four cluster psum GLBs and serialises the words onto a single valid/ready stream.
//   Within a column the beat order is west_0, west_1, east_0, east_1. The output-row
//   index is tracked internally and wraps after NUM_ROWS rows.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   compute_done          level from the array; a rising edge means one row is ready
//   r_req_psum/r_addr_psum  read request and address, broadcast to all four GLBs
//   r_data_psum_*         GLB read data, valid one cycle after r_req_psum
//   out_valid/out_ready   stream handshake
//   out_data              psum word (ReLU-clamped when PSUM_RELU_EN is defined)
//   out_cluster/col/row   beat indices; out_last marks cluster 3 of column X_dim-1
//   row_done/frame_done   1-cycle pulses after the last beat of a row / of a frame
//   overrun               sticky; an edge arrived while a request was already pending
//
// Build option
//   PSUM_RELU_EN          when defined, negative words (MSB set) are emitted as zero
module psum_drain_ctrl #(
  parameter int DATA_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 8,
  parameter int PSUM_LOAD_ADDR = 0,
  parameter int X_dim          = 5,
  parameter int NUM_ROWS       = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     compute_done,
  output logic                     r_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum_west_0,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum_west_1,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum_east_0,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum_east_1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic [1:0]               out_cluster,
  output logic [7:0]               out_col,
  output logic [7:0]               out_row,
  output logic                     out_last,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

  localparam logic [7:0] LAST_COL = 8'(X_dim - 1);
  localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);

  state_t                   state_q, state_d;
  logic                     cd_q, cd_d;
  logic                     pending_q, pending_d;
  logic                     overrun_q, overrun_d;
  logic [7:0]               row_q, row_d;
  logic [7:0]               col_q, col_d;
  logic [1:0]               k_q, k_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [DATA_BITWIDTH-1:0] hold_q [4];
  logic [DATA_BITWIDTH-1:0] hold_d [4];
  logic                     row_done_q, row_done_d;
  logic                     frame_done_q, frame_done_d;

  logic                     cd_rise;
  logic                     take_pending;
  logic [ADDR_BITWIDTH-1:0] cur_addr;
  logic [DATA_BITWIDTH-1:0] beat_data;

  assign cd_rise      = compute_done & ~cd_q;
  assign take_pending = (state_q == S_IDLE) && pending_q;
  assign cur_addr     = ADDR_BITWIDTH'(32'(PSUM_LOAD_ADDR) + 32'(row_q) * 32'(X_dim) + 32'(col_q));

`ifdef PSUM_RELU_EN
  assign beat_data = hold_q[k_q][DATA_BITWIDTH-1] ? '0 : hold_q[k_q];
`else
  assign beat_data = hold_q[k_q];
`endif

  always_comb begin
    state_d      = state_q;
    cd_d         = compute_done;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    row_d        = row_q;
    col_d        = col_q;
    k_d          = k_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;

    // Consumption and a fresh edge in the same cycle leave exactly one request pending;
    // an edge that finds an unconsumed request is dropped and flagged.
    if (take_pending) pending_d = 1'b0;
    if (cd_rise) begin
      if (pending_q && !take_pending) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        addr_d  = cur_addr;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        hold_d[0] = r_data_psum_west_0;
        hold_d[1] = r_data_psum_west_1;
        hold_d[2] = r_data_psum_east_0;
        hold_d[3] = r_data_psum_east_1;
        k_d       = 2'd0;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (k_q != 2'd3) begin
            k_d = k_q + 2'd1;
          end else begin
            k_d = 2'd0;
            if (col_q != LAST_COL) begin
              col_d   = col_q + 8'd1;
              state_d = S_ISSUE;
            end else begin
              col_d      = 8'd0;
              row_done_d = 1'b1;
              state_d    = S_IDLE;
              if (row_q == LAST_ROW) begin
                row_d        = 8'd0;
                frame_done_d = 1'b1;
              end else begin
                row_d = row_q + 8'd1;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cd_q         <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      hold_q       <= '{default: '0};
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      row_q        <= row_d;
      col_q        <= col_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The address is driven live during ISSUE and held afterwards.
  assign r_req_psum  = (state_q == S_ISSUE);
  assign r_addr_psum = r_req_psum ? cur_addr : addr_q;

  assign out_valid   = (state_q == S_EMIT);
  assign out_data    = beat_data;
  assign out_cluster = k_q;
  assign out_col     = col_q;
  assign out_row     = row_q;
  assign out_last    = out_valid && (k_q == 2'd3) && (col_q == LAST_COL);
  assign row_done    = row_done_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
module tb_psum_drain_ctrl;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int LOAD = 0;
  localparam int XD   = 5;
  localparam int NR   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          compute_done;
  logic          r_req_psum;
  logic [AW-1:0] r_addr_psum;
  logic [DW-1:0] rd [4];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_cluster;
  logic [7:0]    out_col;
  logic [7:0]    out_row;
  logic          out_last;
  logic          row_done;
  logic          frame_done;
  logic          overrun;

  psum_drain_ctrl #(
    .DATA_BITWIDTH (DW),
    .ADDR_BITWIDTH (AW),
    .PSUM_LOAD_ADDR(LOAD),
    .X_dim         (XD),
    .NUM_ROWS      (NR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .compute_done      (compute_done),
    .r_req_psum        (r_req_psum),
    .r_addr_psum       (r_addr_psum),
    .r_data_psum_west_0(rd[0]),
    .r_data_psum_west_1(rd[1]),
    .r_data_psum_east_0(rd[2]),
    .r_data_psum_east_1(rd[3]),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_cluster       (out_cluster),
    .out_col           (out_col),
    .out_row           (out_row),
    .out_last          (out_last),
    .row_done          (row_done),
    .frame_done        (frame_done),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  // Four psum GLBs with one-cycle read latency.
  logic [DW-1:0] mem [4][256];
  always @(posedge clk) begin
    if (r_req_psum) begin
      for (int c = 0; c < 4; c++) rd[c] <= mem[c][r_addr_psum];
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [1:0]  cl;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          model_row = 0;
  logic        exp_rd = 1'b0;
  logic        exp_fd = 1'b0;
  logic        exp_ovr = 1'b0;
  logic        stalled = 1'b0;
  logic [35:0] stall_snap;
  int          ready_mode = 0;
  logic        cd_next = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] raw);
`ifdef PSUM_RELU_EN
    return raw[15] ? 16'h0000 : raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic [35:0] snap();
    return {out_valid, out_data, out_cluster, out_col, out_row, out_last};
  endfunction

  // One accepted compute_done edge: the next row, column-major, clusters 0..3.
  task automatic push_row();
    beat_t b;
    for (int col = 0; col < XD; col++) begin
      for (int k = 0; k < 4; k++) begin
        int a;
        a      = (LOAD + model_row * XD + col) % 256;
        b.data = exp_word(mem[k][a]);
        b.cl   = 2'(k);
        b.col  = 8'(col);
        b.row  = 8'(model_row);
        b.last = (col == XD - 1) && (k == 3);
        exp_q.push_back(b);
      end
    end
    model_row = (model_row + 1) % NR;
  endtask

  task automatic step();
    beat_t b;
    @(negedge clk);
    check("row_done", row_done, exp_rd);
    check("frame_done", frame_done, exp_fd);
    check("overrun", overrun, exp_ovr);
    if (stalled) check("stall_hold", snap(), stall_snap);
    exp_rd  = 1'b0;
    exp_fd  = 1'b0;
    stalled = 1'b0;
    compute_done = cd_next;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", out_valid, 1'b0);
        end else begin
          b = exp_q.pop_front();
          check("data", out_data, b.data);
          check("cluster", out_cluster, b.cl);
          check("col", out_col, b.col);
          check("row", out_row, b.row);
          check("last", out_last, b.last);
          if (b.last) begin
            exp_rd = 1'b1;
            exp_fd = (b.row == 8'(NR - 1));
          end
        end
      end else begin
        stalled    = 1'b1;
        stall_snap = snap();
      end
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    cd_next      = 1'b0;
    compute_done = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_req", r_req_psum, 1'b0);
    check("rst_addr", r_addr_psum, '0);
    check("rst_data", out_data, '0);
    check("rst_idx", {out_cluster, out_col, out_row}, '0);
    check("rst_flags", {out_last, row_done, frame_done, overrun}, '0);
    exp_q.delete();
    model_row = 0;
    exp_rd    = 1'b0;
    exp_fd    = 1'b0;
    exp_ovr   = 1'b0;
    stalled   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse(input bit push, input bit ovr);
    cd_next = 1'b1;
    if (push) push_row();
    step();
    if (ovr) exp_ovr = 1'b1;
    step();
    cd_next = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
    check("start_timeout", out_valid, 1'b1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    compute_done = 1'b0;
    out_ready    = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 256; a++) mem[c][a] = 16'(16 * a + c);
    #2;
    do_reset();

    // Single row, sink always ready.
    pulse(1, 0);
    drain(200);

    // Rest of the frame plus the restart at address 0.
    for (int r = 0; r < 5; r++) begin
      pulse(1, 0);
      drain(200);
    end

    // Sink toggling every cycle.
    ready_mode = 1;
    pulse(1, 0);
    drain(400);

    // Edge during a drain is queued; a further edge is dropped as overrun.
    ready_mode = 0;
    pulse(1, 0);
    wait_valid(20);
    pulse(1, 0);
    pulse(0, 1);
    begin
      int n = 0;
      while (exp_q.size() > 20 && n < 200) begin
        step();
        n++;
      end
    end
    step();
    step();
    check("b2b_req", r_req_psum, 1'b1);
    drain(200);
    repeat (10) step();

    // Reset in the middle of a drain.
    pulse(1, 0);
    wait_valid(20);
    repeat (3) step();
    do_reset();
    pulse(1, 0);
    drain(200);

    // Negative and positive words.
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = 16'hFFF6;
      mem[1][a] = 16'h0007;
    end
    pulse(1, 0);
    drain(200);

    // Randomised data, sink readiness and edge spacing.
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 256; a++) mem[c][a] = 16'($urandom);
    ready_mode = 2;
    begin
      int r = 0;
      while (r < 12) begin
        repeat ($urandom_range(0, 3)) step();
        pulse(1, 0);
        r++;
        if (r < 12 && $urandom_range(0, 1) == 1) begin
          wait_valid(20);
          repeat ($urandom_range(0, 5)) step();
          pulse(1, 0);
          r++;
        end
        drain(2000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
